// File: rtl/sdram_bridge_pkg.sv
// ---------------------------------------------------------------------------
// sdram_bridge_pkg
// Shared definitions for the SDRAM host bridge:
//   - bridge FSM state encoding (2-bit enum)
//   - request word layout {we, addr, wdata} packed into the request FIFO
//   - default widths / depths used by the bridge and its FIFO
// Optional feature macro used by the bridge: SDRAM_BRIDGE_TIMEOUT_EN
// ---------------------------------------------------------------------------
package sdram_bridge_pkg;

  localparam int DATA_W          = 16;
  localparam int DEF_HADDR_WIDTH = 24;  // ROW 13 + COL 9 + BANK 2
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_ACK_TIMEOUT = 15;

  // Bridge FSM states, one state per cycle.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } bridge_state_e;

  // Request word layout, LSB first: wdata, then addr, then the we bit on top.
  localparam int REQ_WDATA_LSB = 0;
  localparam int REQ_ADDR_LSB  = DATA_W;

  function automatic int req_width(input int haddr_w);
    return 1 + haddr_w + DATA_W;
  endfunction

  function automatic int req_we_bit(input int haddr_w);
    return REQ_ADDR_LSB + haddr_w;
  endfunction

endpackage

// File: rtl/sdram_req_fifo.sv
// ---------------------------------------------------------------------------
// sdram_req_fifo
// Synchronous request FIFO, registered flags, no bypass path: a pop from a
// full FIFO only frees a slot (full_o drops) from the following cycle.
// Ports:
//   clk, rst   clock, synchronous active-high reset (empties the FIFO)
//   push_i     write din_i (ignored when full)
//   din_i      request word
//   pop_i      drop the head entry (ignored when empty)
//   dout_o     head entry (valid while !empty_o)
//   full_o     FIFO_DEPTH entries held
//   empty_o    no entries held
// ---------------------------------------------------------------------------
import sdram_bridge_pkg::*;

module sdram_req_fifo #(
  parameter int WIDTH = req_width(DEF_HADDR_WIDTH),
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);  // wraps modulo DEPTH (power of two)
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sdram_host_bridge.sv
// ---------------------------------------------------------------------------
// sdram_host_bridge
// Request front-end for the SDRAM controller host port. Client requests are
// queued in sdram_req_fifo; the FSM issues one request at a time as a
// one-cycle rd_enable/wr_enable strobe while busy is low, waits for the
// controller's busy window to open and close, then returns read data as a
// one-cycle rsp_valid pulse (writes complete silently).
//
// Handshake: a request is accepted on a clock edge where req_valid and
// req_ready are both high; req_ready is low during reset and while the FIFO
// is full. rsp_valid / rsp_err / rd_enable / wr_enable are single-cycle pulses.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            client request handshake
//   req_we, req_addr, req_wdata    request payload
//   rsp_valid, rsp_rdata, rsp_err  client response (rsp_rdata held)
//   haddr, data_input              controller address / write data (held)
//   rd_enable, wr_enable           controller strobes
//   busy, data_output              controller status / read data
//
// Optional feature: define SDRAM_BRIDGE_TIMEOUT_EN to abandon a request when
// busy never rises after its strobe (adds ACK_TIMEOUT and drives rsp_err).
// ---------------------------------------------------------------------------
import sdram_bridge_pkg::*;

module sdram_host_bridge #(
  parameter int HADDR_WIDTH = DEF_HADDR_WIDTH,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
  ,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [HADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic [HADDR_WIDTH-1:0] haddr,
  output logic [DATA_W-1:0]      data_input,
  output logic                   rd_enable,
  output logic                   wr_enable,
  input  logic                   busy,
  input  logic [DATA_W-1:0]      data_output
);

  localparam int REQ_W  = req_width(HADDR_WIDTH);
  localparam int WE_BIT = req_we_bit(HADDR_WIDTH);

  // ---------------- request FIFO ----------------
  logic             fifo_push;
  logic             fifo_pop;
  logic [REQ_W-1:0] fifo_din;
  logic [REQ_W-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;

  // Keeps req_ready low through reset and releases it one cycle after.
  logic ready_en_q, ready_en_d;

  assign req_ready = ready_en_q && !fifo_full;
  assign fifo_push = req_valid && req_ready;
  assign fifo_din  = {req_we, req_addr, req_wdata};

  sdram_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .din_i   (fifo_din),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  logic                   head_we;
  logic [HADDR_WIDTH-1:0] head_addr;
  logic [DATA_W-1:0]      head_wdata;

  assign head_we    = fifo_head[WE_BIT];
  assign head_addr  = fifo_head[REQ_ADDR_LSB +: HADDR_WIDTH];
  assign head_wdata = fifo_head[REQ_WDATA_LSB +: DATA_W];

  // ---------------- FSM and output registers ----------------
  bridge_state_e          state_q, state_d;
  logic [HADDR_WIDTH-1:0] haddr_q, haddr_d;
  logic [DATA_W-1:0]      data_input_q, data_input_d;
  logic                   rd_en_q, rd_en_d;
  logic                   wr_en_q, wr_en_d;
  logic                   cur_we_q, cur_we_d;  // direction of the in-flight request
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]      rsp_rdata_q, rsp_rdata_d;

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
  // cnt_q counts cycles since the strobe; loaded with 1 when leaving ISSUE so
  // the abandon pulse lands ACK_TIMEOUT cycles after the strobe cycle.
  localparam logic [3:0] TIMEOUT_LAST = 4'(ACK_TIMEOUT - 1);
  logic [3:0] cnt_q, cnt_d;
  logic       rsp_err_q, rsp_err_d;
`endif

  always_comb begin
    state_d      = state_q;
    haddr_d      = haddr_q;
    data_input_d = data_input_q;
    rd_en_d      = 1'b0;
    wr_en_d      = 1'b0;
    cur_we_d     = cur_we_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    fifo_pop     = 1'b0;
    ready_en_d   = 1'b1;
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
    cnt_d        = cnt_q;
    rsp_err_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && !busy) begin
          fifo_pop     = 1'b1;
          haddr_d      = head_addr;
          data_input_d = head_wdata;
          wr_en_d      = head_we;
          rd_en_d      = !head_we;
          cur_we_d     = head_we;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_ACK;
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
        cnt_d   = 4'd1;
`endif
      end
      WAIT_ACK: begin
        if (busy) begin
          state_d = WAIT_DONE;
        end
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = IDLE;
          rsp_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
`endif
      end
      WAIT_DONE: begin
        if (!busy) begin
          state_d = IDLE;
          if (!cur_we_q) begin
            rsp_rdata_d = data_output;
            rsp_valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      haddr_q      <= '0;
      data_input_q <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      cur_we_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      ready_en_q   <= 1'b0;
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
      cnt_q        <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      haddr_q      <= haddr_d;
      data_input_q <= data_input_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      cur_we_q     <= cur_we_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      ready_en_q   <= ready_en_d;
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
      cnt_q        <= cnt_d;
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  assign haddr      = haddr_q;
  assign data_input = data_input_q;
  assign rd_enable  = rd_en_q;
  assign wr_enable  = wr_en_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_host_bridge.sv
// ---------------------------------------------------------------------------
// tb_sdram_host_bridge
// Directed bench for sdram_host_bridge. A small controller model (enabled by
// model_en) answers strobes with a busy window of busy_len cycles and returns
// stored write data, or addr[15:0]^16'h5A5A for unwritten addresses. With
// model_en low, busy/data_output are driven directly by the step sequence.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
import sdram_bridge_pkg::*;

module tb_sdram_host_bridge;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [23:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [23:0] haddr;
  logic [15:0] data_input;
  logic        rd_enable;
  logic        wr_enable;
  logic        busy;
  logic [15:0] data_output;

  sdram_host_bridge dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .haddr       (haddr),
    .data_input  (data_input),
    .rd_enable   (rd_enable),
    .wr_enable   (wr_enable),
    .busy        (busy),
    .data_output (data_output)
  );

  // ---------------- controller model ----------------
  logic        model_en;
  int          busy_len;
  logic        busy_force;
  logic [15:0] data_force;
  logic        model_busy;
  logic [15:0] model_rdata;
  int          model_cnt;
  logic [15:0] model_mem [logic [23:0]];

  assign busy        = model_en ? model_busy  : busy_force;
  assign data_output = model_en ? model_rdata : data_force;

  always @(posedge clk) begin
    if (rst) begin
      model_busy <= 1'b0;
      model_cnt  <= 0;
    end else if (model_en && model_cnt == 0 && (rd_enable || wr_enable)) begin
      model_busy <= 1'b1;
      model_cnt  <= busy_len;
      if (wr_enable) model_mem[haddr] = data_input;
      else model_rdata <= model_mem.exists(haddr) ? model_mem[haddr] : (haddr[15:0] ^ 16'h5A5A);
    end else if (model_cnt > 1) begin
      model_cnt <= model_cnt - 1;
    end else if (model_cnt == 1) begin
      model_cnt  <= 0;
      model_busy <= 1'b0;
    end
  end

  // ---------------- monitor ----------------
  int          rd_cnt, wr_cnt, rsp_cnt, err_cnt, pulse_viol;
  logic        prev_rd, prev_wr, prev_rsp;
  logic [23:0] strobe_q [$];
  logic [15:0] got_q [$];

  initial begin
    rd_cnt = 0; wr_cnt = 0; rsp_cnt = 0; err_cnt = 0; pulse_viol = 0;
    prev_rd = 1'b0; prev_wr = 1'b0; prev_rsp = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (rd_enable) begin
        rd_cnt <= rd_cnt + 1;
        strobe_q.push_back(haddr);
      end
      if (wr_enable) wr_cnt <= wr_cnt + 1;
      if (rsp_valid) begin
        rsp_cnt <= rsp_cnt + 1;
        got_q.push_back(rsp_rdata);
      end
      if (rsp_err) err_cnt <= err_cnt + 1;
      if ((rd_enable && prev_rd) || (wr_enable && prev_wr) || (rsp_valid && prev_rsp) ||
          (rd_enable && wr_enable))
        pulse_viol <= pulse_viol + 1;
    end
    prev_rd  <= rd_enable;
    prev_wr  <= wr_enable;
    prev_rsp <= rsp_valid;
  end

  // ---------------- scoreboard / check helpers ----------------
  logic [15:0] exp_q [$];
  int          errors;
  int          checks;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the request until accepted (bounded).
  task automatic send(input logic we, input logic [23:0] addr, input logic [15:0] wdata);
    logic ok;
    ok        = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    for (int i = 0; i < 60; i++) begin
      if (req_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    req_valid = 1'b0;
    check("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_rsp(input int target);
    for (int i = 0; i < 200; i++) begin
      if (rsp_cnt >= target) break;
      tick();
    end
    check("wait_rsp", 32'(rsp_cnt >= target), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  int base;
  int t_cnt;

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 24'h000005; req_wdata = 16'h0;
    model_en = 1'b0; busy_len = 3; busy_force = 1'b0; data_force = 16'h0; model_rdata = 16'h0;

    // 1. reset held 3 cycles with req_valid high
    tick(); tick(); tick();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rd_en", 32'(rd_enable), 32'd0);
    check("rst_wr_en", 32'(wr_enable), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_haddr", 32'(haddr), 32'd0);
    check("rst_data_input", 32'(data_input), 32'd0);
    rst = 1'b0; req_valid = 1'b0;
    tick();
    check("post_rst_ready", 32'(req_ready), 32'd1);
    tick(); tick(); tick();
    check("rst_nothing_queued", 32'(rd_cnt + wr_cnt), 32'd0);

    // 2. write then read the same address
    model_en = 1'b1; busy_len = 3;
    send(1'b1, 24'h000123, 16'hBEEF);
    send(1'b0, 24'h000123, 16'h0000);
    exp_q.push_back(16'hBEEF);
    wait_rsp(1);
    tick(); tick();
    check("wr_strobes", 32'(wr_cnt), 32'd1);
    check("rd_strobes", 32'(rd_cnt), 32'd1);
    check("rsp_count", 32'(rsp_cnt), 32'd1);
    check("rsp_rdata_held", 32'(rsp_rdata), 32'h0000BEEF);
    check("haddr_held", 32'(haddr), 32'h00000123);

    // 3. fill the FIFO while busy holds the bridge off
    model_en = 1'b0; busy_force = 1'b1;
    strobe_q.delete();
    base = rd_cnt;
    req_valid = 1'b1; req_we = 1'b0; req_wdata = 16'h0;
    for (int i = 0; i < 4; i++) begin
      req_addr = 24'h00000A + 24'(i);
      check("full_ready_slot", 32'(req_ready), 32'd1);
      tick();
    end
    req_addr = 24'h00000E;
    check("full_ready_low", 32'(req_ready), 32'd0);
    tick(); tick(); tick();
    check("full_ready_stays_low", 32'(req_ready), 32'd0);
    check("full_no_strobe", 32'(rd_cnt - base), 32'd0);
    model_en = 1'b1; busy_len = 1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) break;
      tick();
    end
    check("full_release_strobe", 32'(rd_enable), 32'd1);
    check("full_release_haddr", 32'(haddr), 32'h0000000A);
    tick();
    req_valid = 1'b0;
    exp_q.push_back(16'h5A50); exp_q.push_back(16'h5A51); exp_q.push_back(16'h5A56);
    exp_q.push_back(16'h5A57); exp_q.push_back(16'h5A54);
    wait_rsp(6);
    tick(); tick();
    check("full_strobe_count", 32'(strobe_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (strobe_q.size() > 0) check("full_strobe_order", 32'(strobe_q.pop_front()), 32'h0000000A + 32'(i));
    end

    // 4. busy gating, controller driven by hand
    model_en = 1'b0; busy_force = 1'b1; data_force = 16'h0;
    send(1'b0, 24'h000200, 16'h0);
    base = rd_cnt;
    tick(); tick(); tick(); tick();
    check("gate_no_strobe_cnt", 32'(rd_cnt - base), 32'd0);
    check("gate_no_strobe", 32'(rd_enable), 32'd0);
    busy_force = 1'b0;
    tick();
    check("gate_strobe_next", 32'(rd_enable), 32'd1);
    check("gate_haddr", 32'(haddr), 32'h00000200);
    tick();
    check("gate_strobe_one_cycle", 32'(rd_enable), 32'd0);
    busy_force = 1'b1; data_force = 16'h1234;
    tick();
    busy_force = 1'b0;
    exp_q.push_back(16'h1234);
    tick();
    check("gate_rsp_valid", 32'(rsp_valid), 32'd1);
    check("gate_rsp_rdata", 32'(rsp_rdata), 32'h00001234);
    tick();
    check("gate_rsp_pulse", 32'(rsp_valid), 32'd0);

    // 5. reset while a read is in WAIT_DONE, second read still queued
    busy_force = 1'b1;
    send(1'b0, 24'h000300, 16'h0);
    send(1'b0, 24'h000301, 16'h0);
    busy_force = 1'b0;
    tick();
    check("mid_strobe", 32'(rd_enable), 32'd1);
    tick();
    busy_force = 1'b1;
    tick();
    check("mid_state_wait_done", 32'(dut.state_q), 32'(WAIT_DONE));
    base = rsp_cnt;
    rst = 1'b1; busy_force = 1'b0; data_force = 16'hDEAD;
    tick();
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_state_idle", 32'(dut.state_q), 32'(IDLE));
    check("mid_rst_fifo_empty", 32'(dut.fifo_empty), 32'd1);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    t_cnt = rd_cnt;
    tick();
    check("mid_post_ready", 32'(req_ready), 32'd1);
    tick(); tick(); tick(); tick();
    check("mid_no_rsp", 32'(rsp_cnt - base), 32'd0);
    check("mid_queue_dropped", 32'(rd_cnt - t_cnt), 32'd0);

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
    // 6. busy never rises: request abandoned with rsp_err
    busy_force = 1'b0; model_en = 1'b0;
    base = rsp_cnt;
    send(1'b0, 24'h000400, 16'h0);
    for (int i = 0; i < 20; i++) begin
      if (rd_enable) break;
      tick();
    end
    check("to_strobe", 32'(rd_enable), 32'd1);
    t_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      t_cnt++;
      if (rsp_err) break;
    end
    check("to_err_latency", 32'(t_cnt), 32'd15);
    tick();
    check("to_err_pulse", 32'(rsp_err), 32'd0);
    check("to_no_rsp", 32'(rsp_cnt - base), 32'd0);
    model_en = 1'b1; busy_len = 2;
    send(1'b0, 24'h000401, 16'h0);
    exp_q.push_back(16'h5E5B);
    wait_rsp(base + 1);
    check("to_err_count", 32'(err_cnt), 32'd1);
`endif

    // final scoreboard drain
    tick(); tick();
    check("sb_count", 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      check("sb_rdata", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    end
    check("pulse_shape", 32'(pulse_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
